uart_tx_engine: RTL and testbench

Serial transmitter for the board-level UART link. Accepts one parallel byte per handshake and drives the Tx pin with a framed, LSB-first asynchronous character: start bit, data bits, optional parity, stop. Bit timing derives from an internal oversample tick generator that uses the same baud and sample arithmetic as the receive side. The peer's Rx pin, or a loopback of it, is the consumer.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_tx_engine.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_engine.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, baud divisor arithmetic
// and the default link parameters used by both the transmitter and receiver.
package uart_pkg;

    localparam int DEFAULT_DATA_BITS      = 8;
    localparam int DEFAULT_STOP_BIT_TICKS = 16;
    localparam int DEFAULT_BAUD_RATE      = 19200;
    localparam int DEFAULT_CLOCK_RATE     = 50000000;
    localparam int DEFAULT_SAMPLE_RATE    = 16;
    localparam int DEFAULT_PARITY_EN      = 0;
    localparam int DEFAULT_PARITY_ODD     = 0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Clocks per oversample tick; integer division, so the bit rate rounds up slightly.
    function automatic int calc_div(input int clock, input int baud, input int sample);
        return clock / (baud * sample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: a free-running 0..DIV-1 counter with a one-cycle
// Tick at the terminal count. Clear restarts the period so a frame starts aligned.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    output logic Tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        if (Clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: accepts a parallel word on TxStart and shifts out a framed,
// LSB-first character (start, data, optional parity, stop) with registered outputs.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_BITS      = DEFAULT_DATA_BITS,
    parameter int STOP_BIT_TICKS = DEFAULT_STOP_BIT_TICKS,
    parameter int BAUD_RATE      = DEFAULT_BAUD_RATE,
    parameter int CLOCK_RATE     = DEFAULT_CLOCK_RATE,
    parameter int SAMPLE_RATE    = DEFAULT_SAMPLE_RATE,
    parameter int PARITY_EN      = DEFAULT_PARITY_EN,
    parameter int PARITY_ODD     = DEFAULT_PARITY_ODD
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 TxStart,
    input  logic [DATA_BITS-1:0] TxData,
    output logic                 Tx,
    output logic                 TxBusy,
    output logic                 TxDone
);

    localparam int DIV  = calc_div(CLOCK_RATE, BAUD_RATE, SAMPLE_RATE);
    localparam int SMAX = (SAMPLE_RATE > STOP_BIT_TICKS) ? SAMPLE_RATE : STOP_BIT_TICKS;
    localparam int SW   = $clog2(SMAX);
    localparam int BW   = $clog2(DATA_BITS);

    if (DIV < 1) begin : g_div_check
        $error("uart_tx_engine: baud divisor must be at least 1");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bits_check
        $error("uart_tx_engine: DATA_BITS must be within 5..9");
    end

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [SW-1:0]        sample_q, sample_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic accept;
    logic tick;
    logic last_tick;
    logic slot_end;

    assign accept = (state_q == IDLE) && TxStart;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (accept),
        .Tick  (tick)
    );

    // The stop bit has its own length; every other slot is SAMPLE_RATE ticks.
    assign last_tick = (state_q == STOP) ? (sample_q == SW'(STOP_BIT_TICKS - 1))
                                         : (sample_q == SW'(SAMPLE_RATE - 1));
    assign slot_end  = tick && last_tick;

    // NOTE: every *_d gets a default before the case so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        sample_d = sample_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if ((state_q != IDLE) && tick) begin
            sample_d = last_tick ? '0 : sample_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (TxStart) begin
                    state_d  = START;
                    shift_d  = TxData;
                    parity_d = (^TxData) ^ 1'(PARITY_ODD);
                    sample_d = '0;
                    bit_d    = '0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                if (slot_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (slot_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (slot_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (slot_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                sample_d = '0;
                bit_d    = '0;
                tx_d     = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop sees
    // the pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            parity_q <= 1'b0;
            sample_q <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            sample_q <= sample_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Tx     = tx_q;
    assign TxBusy = busy_q;
    assign TxDone = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: expected Tx levels are queued per cycle
// from a bench-side frame model and popped as the selected DUT drives the line.
module tb_uart_tx_engine;

    localparam int NDUT = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       start_w [NDUT];
    logic       tx_w    [NDUT];
    logic       busy_w  [NDUT];
    logic       done_w  [NDUT];

    int   sel;
    logic mon_tx, mon_busy, mon_done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic exp_q [$];
    logic obs   [$];
    int   w_done [$];
    int   w_busy;
    int   w_bad;
    int   w_left;

    always #5 clk = ~clk;

    always_comb begin
        mon_tx   = tx_w[sel];
        mon_busy = busy_w[sel];
        mon_done = done_w[sel];
    end

    // 0: 8N1, DIV=1
    uart_tx_engine #(.CLOCK_RATE(1600), .BAUD_RATE(100), .SAMPLE_RATE(16)) dut_8n1 (
        .Clock(clk), .Reset(rst), .TxStart(start_w[0]), .TxData(tx_data),
        .Tx(tx_w[0]), .TxBusy(busy_w[0]), .TxDone(done_w[0]));
    // 1: 8E1
    uart_tx_engine #(.CLOCK_RATE(1600), .BAUD_RATE(100), .SAMPLE_RATE(16),
                     .PARITY_EN(1), .PARITY_ODD(0)) dut_8e1 (
        .Clock(clk), .Reset(rst), .TxStart(start_w[1]), .TxData(tx_data),
        .Tx(tx_w[1]), .TxBusy(busy_w[1]), .TxDone(done_w[1]));
    // 2: 8O1
    uart_tx_engine #(.CLOCK_RATE(1600), .BAUD_RATE(100), .SAMPLE_RATE(16),
                     .PARITY_EN(1), .PARITY_ODD(1)) dut_8o1 (
        .Clock(clk), .Reset(rst), .TxStart(start_w[2]), .TxData(tx_data),
        .Tx(tx_w[2]), .TxBusy(busy_w[2]), .TxDone(done_w[2]));
    // 3: 8E2
    uart_tx_engine #(.CLOCK_RATE(1600), .BAUD_RATE(100), .SAMPLE_RATE(16),
                     .PARITY_EN(1), .PARITY_ODD(0), .STOP_BIT_TICKS(32)) dut_8e2 (
        .Clock(clk), .Reset(rst), .TxStart(start_w[3]), .TxData(tx_data),
        .Tx(tx_w[3]), .TxBusy(busy_w[3]), .TxDone(done_w[3]));
    // 4: default parameters, DIV=162
    uart_tx_engine dut_default (
        .Clock(clk), .Reset(rst), .TxStart(start_w[4]), .TxData(tx_data),
        .Tx(tx_w[4]), .TxBusy(busy_w[4]), .TxDone(done_w[4]));

    // Model of one frame: start, 8 data bits LSB first, optional parity, stop.
    task automatic push_frame(input logic [7:0] d, input bit par_en, input bit odd,
                              input int unit, input int stop_len);
        repeat (unit) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (unit) exp_q.push_back(d[i]);
        end
        if (par_en) begin
            repeat (unit) exp_q.push_back((^d) ^ odd);
        end
        repeat (stop_len) exp_q.push_back(1'b1);
    endtask

    // Called at a negedge; pulses TxStart across one rising edge, returns at the
    // negedge of cycle 1 of the frame.
    task automatic send(input int idx, input logic [7:0] d);
        start_w[idx] = 1'b1;
        tx_data      = d;
        @(negedge clk);
        start_w[idx] = 1'b0;
    endtask

    // Samples the selected DUT once per cycle, popping the scoreboard, until the
    // n-th TxDone or the cycle budget runs out.
    task automatic watch(input int n_done, input int budget);
        logic e;
        w_done.delete();
        obs.delete();
        w_busy = 0;
        w_bad  = -1;
        for (int c = 1; c <= budget; c++) begin
            obs.push_back(mon_tx);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if ((mon_tx !== e) && (w_bad < 0)) w_bad = c;
            end
            if (mon_busy === 1'b1) w_busy++;
            if (mon_done === 1'b1) begin
                w_done.push_back(c);
                if (w_done.size() == n_done) break;
            end
            @(negedge clk);
        end
        w_left = exp_q.size();
        exp_q.delete();
    endtask

    function automatic int done_at(input int n);
        return (w_done.size() > n) ? w_done[n] : -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tx_data = 8'h00;
        for (int i = 0; i < NDUT; i++) start_w[i] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            total_cnt++;
            if ({tx_w[i], busy_w[i], done_w[i]} !== 3'b100) begin
                $display("FAIL reset_state dut%0d: tx/busy/done=%b%b%b expected 100",
                         i, tx_w[i], busy_w[i], done_w[i]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_basic();
        sel = 0;
        push_frame(8'hA5, 1'b0, 1'b0, 16, 16);
        send(0, 8'hA5);
        watch(1, 300);
        total_cnt++;
        if ((w_bad >= 0) || (w_left != 0)) begin
            $display("FAIL basic_wave: first bad cycle %0d, %0d levels unseen, expected none", w_bad, w_left);
        end else pass_cnt++;
        total_cnt++;
        if (done_at(0) != 161) begin
            $display("FAIL basic_done: TxDone at cycle %0d expected 161", done_at(0));
        end else pass_cnt++;
        total_cnt++;
        if (w_busy != 160) begin
            $display("FAIL basic_busy: busy for %0d cycles expected 160", w_busy);
        end else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({mon_done, mon_busy, mon_tx} !== 3'b001) begin
            $display("FAIL basic_after: done/busy/tx=%b%b%b expected 001", mon_done, mon_busy, mon_tx);
        end else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        bit quiet;
        sel = 0;
        push_frame(8'hA5, 1'b0, 1'b0, 16, 16);
        send(0, 8'hA5);
        fork
            watch(1, 300);
            begin
                repeat (50) @(negedge clk);
                start_w[0] = 1'b1;
                tx_data    = 8'h3C;
                @(negedge clk);
                start_w[0] = 1'b0;
            end
        join
        total_cnt++;
        if ((w_bad >= 0) || (w_left != 0)) begin
            $display("FAIL ignore_wave: first bad cycle %0d, %0d levels unseen, expected none", w_bad, w_left);
        end else pass_cnt++;
        total_cnt++;
        if (done_at(0) != 161) begin
            $display("FAIL ignore_done: TxDone at cycle %0d expected 161", done_at(0));
        end else pass_cnt++;
        quiet = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if ((mon_tx !== 1'b1) || (mon_busy !== 1'b0)) quiet = 1'b0;
        end
        total_cnt++;
        if (!quiet) begin
            $display("FAIL ignore_no_second_frame: line active=%0b expected 0", !quiet);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        sel = 0;
        push_frame(8'h00, 1'b0, 1'b0, 16, 16);
        exp_q.push_back(1'b1);
        push_frame(8'hFF, 1'b0, 1'b0, 16, 16);
        start_w[0] = 1'b1;
        tx_data    = 8'h00;
        @(negedge clk);
        tx_data    = 8'hFF;
        fork
            watch(2, 500);
            begin
                repeat (161) @(negedge clk);
                start_w[0] = 1'b0;
            end
        join
        total_cnt++;
        if ((w_bad >= 0) || (w_left != 0)) begin
            $display("FAIL b2b_wave: first bad cycle %0d, %0d levels unseen, expected none", w_bad, w_left);
        end else pass_cnt++;
        total_cnt++;
        if (done_at(0) != 161) begin
            $display("FAIL b2b_done1: TxDone at cycle %0d expected 161", done_at(0));
        end else pass_cnt++;
        total_cnt++;
        if (done_at(1) != 322) begin
            $display("FAIL b2b_done2: TxDone at cycle %0d expected 322", done_at(1));
        end else pass_cnt++;
        total_cnt++;
        if (w_busy != 320) begin
            $display("FAIL b2b_busy: busy for %0d cycles expected 320", w_busy);
        end else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_parity(input int idx, input bit odd, input int stop_len);
        logic exp_par;
        int   exp_done;
        sel      = idx;
        exp_par  = (^8'h07) ^ odd;
        exp_done = 16 * 10 + stop_len + 1;
        push_frame(8'h07, 1'b1, odd, 16, stop_len);
        send(idx, 8'h07);
        watch(1, 400);
        total_cnt++;
        if ((w_bad >= 0) || (w_left != 0)) begin
            $display("FAIL parity_wave dut%0d: first bad cycle %0d, %0d levels unseen, expected none",
                     idx, w_bad, w_left);
        end else pass_cnt++;
        total_cnt++;
        if ((obs.size() <= 152) || (obs[152] !== exp_par)) begin
            $display("FAIL parity_bit dut%0d: got %b expected %b", idx,
                     (obs.size() > 152) ? obs[152] : 1'bx, exp_par);
        end else pass_cnt++;
        total_cnt++;
        if (done_at(0) != exp_done) begin
            $display("FAIL parity_done dut%0d: TxDone at cycle %0d expected %0d", idx, done_at(0), exp_done);
        end else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        bit quiet;
        sel = 0;
        send(0, 8'hA5);
        repeat (69) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if ({mon_tx, mon_busy, mon_done} !== 3'b100) begin
            $display("FAIL midreset_state: tx/busy/done=%b%b%b expected 100", mon_tx, mon_busy, mon_done);
        end else pass_cnt++;
        quiet = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if ((mon_done !== 1'b0) || (mon_tx !== 1'b1) || (mon_busy !== 1'b0)) quiet = 1'b0;
        end
        total_cnt++;
        if (!quiet) begin
            $display("FAIL midreset_quiet: line active=%0b expected 0", !quiet);
        end else pass_cnt++;
        rst        = 1'b1;
        start_w[0] = 1'b1;
        tx_data    = 8'hC3;
        @(negedge clk);
        rst        = 1'b0;
        start_w[0] = 1'b0;
        total_cnt++;
        if ({mon_tx, mon_busy} !== 2'b10) begin
            $display("FAIL reset_beats_start: tx/busy=%b%b expected 10", mon_tx, mon_busy);
        end else pass_cnt++;
        push_frame(8'h55, 1'b0, 1'b0, 16, 16);
        send(0, 8'h55);
        watch(1, 300);
        total_cnt++;
        if ((w_bad >= 0) || (w_left != 0) || (done_at(0) != 161)) begin
            $display("FAIL midreset_clean_frame: bad cycle %0d, unseen %0d, done %0d, expected -1/0/161",
                     w_bad, w_left, done_at(0));
        end else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_default_params();
        int zeros;
        sel = 4;
        push_frame(8'h80, 1'b0, 1'b0, 2592, 2592);
        send(4, 8'h80);
        watch(1, 26100);
        total_cnt++;
        if ((w_bad >= 0) || (w_left != 0)) begin
            $display("FAIL default_wave: first bad cycle %0d, %0d levels unseen, expected none", w_bad, w_left);
        end else pass_cnt++;
        zeros = 0;
        while ((zeros < obs.size()) && (obs[zeros] === 1'b0)) zeros++;
        total_cnt++;
        if (zeros != 8 * 2592) begin
            $display("FAIL default_low_run: low for %0d cycles expected %0d", zeros, 8 * 2592);
        end else pass_cnt++;
        total_cnt++;
        if ((done_at(0) != 25921) || (w_busy != 25920)) begin
            $display("FAIL default_frame_len: done %0d busy %0d expected 25921/25920", done_at(0), w_busy);
        end else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        sel = 0;
        test_reset();
        test_basic();
        test_busy_ignore();
        test_back_to_back();
        test_parity(1, 1'b0, 16);
        test_parity(2, 1'b1, 16);
        test_parity(3, 1'b0, 32);
        test_reset_mid_frame();
        test_default_params();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
